bcd_scan_driver: RTL and testbench

- Upstream feeder for the per-digit BCD-to-7-segment decoder.
- Accepts a binary value and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the four digits onto one shared digit bus (n, on) and drives a one-hot active-low anode select.
- One decoder instance downstream consumes n/on; sel goes directly to the board anodes.

---
 rtl/bcd_scan_driver_pkg.sv | 29 ++
 rtl/bcd_scan_driver_bin2bcd_seq.sv | 61 ++++++
 rtl/bcd_scan_driver.sv | 68 ++++++
 tb/tb_bcd_scan_driver.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bcd_scan_driver_pkg.sv
// Shared constants, FSM encoding and the double-dabble adjust step for the
// BCD scan driver.
package bcd_scan_driver_pkg;

  localparam int DIGITS  = 4;
  localparam int BCD_W   = 16;
  localparam int BIN_W   = 14;
  localparam int MAX_VAL = 9999;
  localparam int ITERS   = BIN_W;

  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  // Add 3 to every nibble >= 5 so the following shift carries correctly.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int d = 0; d < DIGITS; d++) begin
      if (r[d*4 +: 4] >= 4'd5) r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_scan_driver_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-add-3 iteration per cycle,
// busy for 15 cycles after an accepted load, one-cycle done pulse at the end.
module bin2bcd_seq
  import bcd_scan_driver_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             ovf,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  conv_state_t      state, nxt;
  logic [3:0]       iter;
  logic [BIN_W-1:0] bin;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (load) nxt = CONV;
      CONV:    if (iter == 4'(ITERS-1)) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter <= '0;
      bin  <= '0;
      bcd  <= '0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          bin  <= (value > MAX_BIN) ? MAX_BIN : value;
          ovf  <= (value > MAX_BIN);
          bcd  <= '0;
          iter <= '0;
        end
        CONV: begin
          {bcd, bin} <= {bcd_adjust(bcd), bin} << 1;
          iter       <= iter + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: rtl/bcd_scan_driver.sv
// Converts a binary value to four BCD digits and time-multiplexes them onto
// one digit bus with active-low one-hot anode select and leading-zero blanking.
module bcd_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BIN_W       = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  input  logic             blank_lz,
  output logic             busy,
  output logic             ovf,
  output logic [3:0]       n,
  output logic             on,
  output logic [3:0]       sel
);
  import bcd_scan_driver_pkg::DIGITS;
  import bcd_scan_driver_pkg::BCD_W;

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [BCD_W-1:0]            bcd;
  logic                        done;
  logic [DIGITS-1:0][3:0]      disp;
  logic [DIV_W-1:0]            cnt;
  logic [1:0]                  idx;
  logic [DIGITS-1:0]           lz;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .busy  (busy),
    .ovf   (ovf),
    .bcd   (bcd),
    .done  (done)
  );

  // Display only changes on done, so partial conversions are never scanned out.
  always_ff @(posedge clk) begin
    if (rst)       disp <= '0;
    else if (done) disp <= bcd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == DIV_W'(REFRESH_DIV-1)) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // lz[k]: digit k and every higher digit are zero.
  for (genvar k = 0; k < DIGITS; k++) begin : g_lz
    assign lz[k] = ~|disp[DIGITS-1:k];
  end

  assign n   = disp[idx];
  assign sel = ~(4'b0001 << idx);
  assign on  = blank_lz && (idx != 2'd0) && lz[idx];

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Randomized and directed bench for bcd_scan_driver against an arithmetic
// reference model (decimal digits by division, scan position by cycle count).
module tb_bcd_scan_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst, load, blank_lz;
  logic [13:0] value;
  logic        busy, ovf, on;
  logic [3:0]  n, sel;

  int checks = 0;
  int fails  = 0;

  // reference model state
  int ncyc, rem, mdisp, pend;
  bit movf;
  int p10 [5] = '{1, 10, 100, 1000, 10000};

  bcd_scan_driver #(.REFRESH_DIV(DIV), .BIN_W(14)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
    .busy(busy), .ovf(ovf), .n(n), .on(on), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h (cycle %0d disp %0d)", tag, got, exp, ncyc, mdisp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      ncyc = 0; rem = 0; mdisp = 0; movf = 0;
    end else begin
      ncyc++;
      if (rem > 0) begin
        rem--;
        if (rem == 0) mdisp = pend;
      end else if (load) begin
        pend = (int'(value) > 9999) ? 9999 : int'(value);
        movf = (int'(value) > 9999);
        rem  = 15;
      end
    end
  endtask

  task automatic check_all();
    int i;
    logic [3:0] e_n, e_sel;
    logic e_on;
    i     = (ncyc / DIV) % 4;
    e_n   = 4'((mdisp / p10[i]) % 10);
    e_sel = ~(4'b0001 << i);
    e_on  = blank_lz && (i > 0) && (mdisp < p10[i]);
    chk("busy", {3'b0, busy}, {3'b0, rem > 0});
    chk("ovf",  {3'b0, ovf},  {3'b0, movf});
    chk("n",    n,            e_n);
    chk("sel",  sel,          e_sel);
    chk("on",   {3'b0, on},   {3'b0, e_on});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int c);
    for (int i = 0; i < c; i++) step();
  endtask

  task automatic do_load(input int v);
    value = 14'(v);
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; blank_lz = 1'b0; value = '0;
    ncyc = 0; rem = 0; mdisp = 0; pend = 0; movf = 0;
    @(posedge clk); @(posedge clk); #1;
    // reset state against fixed constants
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_ovf",  {3'b0, ovf},  4'd0);
    chk("rst_n",    n,            4'd0);
    chk("rst_on",   {3'b0, on},   4'd0);
    chk("rst_sel",  sel,          4'b1110);
    rst = 1'b0;

    do_load(1234);
    run(15);
    chk("busy_after_15", {3'b0, busy}, 4'd0);
    run(20);

    blank_lz = 1'b1;
    do_load(7);
    run(30);
    blank_lz = 1'b0;
    run(10);

    blank_lz = 1'b1;
    do_load(0);    run(32);
    do_load(1000); run(32);

    do_load(12000); run(20);
    do_load(5);     run(20);

    // loads while busy, including the DONE cycle, must be dropped
    do_load(4321);
    value = 14'd1111;
    run(2);
    load = 1'b1; step(); load = 1'b0;
    while (rem != 1) step();
    load = 1'b1; step(); load = 1'b0;
    run(20);
    chk("collide_n_digit", 4'(mdisp % 10), 4'd1);

    // reset in the middle of a conversion
    do_load(8765);
    run(6);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_sel", sel, 4'b1110);
    chk("midrst_busy", {3'b0, busy}, 4'd0);
    do_load(42); run(20);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      value = 14'($urandom_range(0, 16383));
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      rst   = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
